// File: rtl/morty_lsu.sv
// Load/store unit: turns one MEM-stage access into one Wishbone B4 classic cycle,
// returning lane-aligned, extended load data and an error flag while stalling the pipe.
module morty_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic        lsu_read_i,
    input  logic        lsu_write_i,
    input  logic        lsu_word_i,
    input  logic        lsu_hw_i,
    input  logic        lsu_byte_i,
    input  logic        lsu_unsigned_i,
    input  logic        lsu_kill_i,
    input  logic        lsu_hold_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_err_o,
    output logic        lsu_stall_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST =
        TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t        state, state_next;
    size_t         req_size, size_q;
    logic [TW-1:0] timer_q;
    logic [1:0]    lo_q;
    logic          uns_q, killed_q, err_q;
    logic [31:0]   data_q;

    logic          misaligned, req_valid, timeout_hit, bus_done;
    logic          issue, finish;
    logic [31:0]   st_dat, ld_data;
    logic [3:0]    st_sel;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    // Size priority word > hw > byte; no flag at all means word.
    always_comb begin
        req_size = SZ_WORD;
        if (lsu_word_i)     req_size = SZ_WORD;
        else if (lsu_hw_i)  req_size = SZ_HALF;
        else if (lsu_byte_i) req_size = SZ_BYTE;
    end

    assign misaligned = ((req_size == SZ_WORD) && (lsu_addr_i[1:0] != 2'b00)) ||
                        ((req_size == SZ_HALF) && lsu_addr_i[0]);
    assign req_valid  = (lsu_read_i | lsu_write_i) & ~misaligned & ~lsu_kill_i;

    always_comb begin
        st_dat = lsu_wdata_i;
        st_sel = 4'b1111;
        case (req_size)
            SZ_BYTE: begin
                st_dat = {4{lsu_wdata_i[7:0]}};
                st_sel = 4'b0001 << lsu_addr_i[1:0];
            end
            SZ_HALF: begin
                st_dat = {2{lsu_wdata_i[15:0]}};
                st_sel = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_dat = lsu_wdata_i;
                st_sel = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = wbm_dat_i[{lo_q, 3'b000} +: 8];
        ld_half = wbm_dat_i[{lo_q[1], 4'b0000} +: 16];
        case (size_q)
            SZ_BYTE: ld_data = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = wbm_dat_i;
        endcase
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TIMER_LAST);
    assign bus_done    = wbm_ack_i | wbm_err_i | timeout_hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        lsu_stall_o = 1'b0;
        issue       = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                lsu_stall_o = req_valid;
                if (req_valid) begin
                    issue      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                lsu_stall_o = 1'b1;
                if (bus_done) begin
                    finish     = 1'b1;
                    state_next = (killed_q | lsu_kill_i) ? IDLE : DONE;
                end
            end
            DONE: begin
                if (lsu_kill_i || !lsu_hold_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            wbm_we_o  <= 1'b0;
            wbm_cyc_o <= 1'b0;
            lo_q      <= '0;
            size_q    <= SZ_WORD;
            uns_q     <= 1'b0;
            killed_q  <= 1'b0;
            timer_q   <= '0;
            err_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            if (issue) begin
                wbm_adr_o <= {lsu_addr_i[31:2], 2'b00};
                wbm_dat_o <= st_dat;
                wbm_sel_o <= st_sel;
                wbm_we_o  <= lsu_write_i;
                wbm_cyc_o <= 1'b1;
                lo_q      <= lsu_addr_i[1:0];
                size_q    <= req_size;
                uns_q     <= lsu_unsigned_i;
                killed_q  <= 1'b0;
                timer_q   <= '0;
            end
            if (state == BUSY) begin
                timer_q <= timer_q + TW'(1);
                if (lsu_kill_i) killed_q <= 1'b1;
            end
            // Neither ack nor err at completion means the timer forced it.
            if (finish) begin
                wbm_cyc_o <= 1'b0;
                wbm_we_o  <= 1'b0;
                err_q     <= wbm_err_i | ~wbm_ack_i;
                data_q    <= (wbm_we_o || wbm_err_i || !wbm_ack_i) ? 32'h0 : ld_data;
            end
        end
    end

    assign wbm_stb_o  = wbm_cyc_o;
    assign lsu_data_o = (state == DONE) ? data_q : 32'h0;
    assign lsu_err_o  = (state == DONE) ? err_q : 1'b0;

endmodule

// File: tb/tb_morty_lsu.sv
// Self-checking bench for morty_lsu: directed scenarios plus randomized accesses
// compared against an arithmetic model of lane selection and load extension.
module tb_morty_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lsu_addr, lsu_wdata, lsu_data, wbm_adr, wbm_dat, wbm_dat_in;
    logic        lsu_read, lsu_write, lsu_word, lsu_hw, lsu_byte, lsu_unsigned;
    logic        lsu_kill, lsu_hold, lsu_err, lsu_stall;
    logic [3:0]  wbm_sel;
    logic        wbm_we, wbm_cyc, wbm_stb, wbm_ack, wbm_err;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    morty_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
        .lsu_read_i(lsu_read), .lsu_write_i(lsu_write),
        .lsu_word_i(lsu_word), .lsu_hw_i(lsu_hw), .lsu_byte_i(lsu_byte),
        .lsu_unsigned_i(lsu_unsigned), .lsu_kill_i(lsu_kill), .lsu_hold_i(lsu_hold),
        .lsu_data_o(lsu_data), .lsu_err_o(lsu_err), .lsu_stall_o(lsu_stall),
        .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat), .wbm_sel_o(wbm_sel),
        .wbm_we_o(wbm_we), .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb),
        .wbm_dat_i(wbm_dat_in), .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err)
    );

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic w, input logic h, input logic b);
        if (w) return 4;
        if (h) return 2;
        if (b) return 1;
        return 4;
    endfunction

    function automatic logic is_misaligned(input int n, input logic [31:0] addr);
        return (n == 4 && (addr % 4) != 0) || (n == 2 && (addr % 2) != 0);
    endfunction

    function automatic logic [31:0] model_wdat(input int n, input logic [31:0] wd);
        if (n == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [3:0] model_sel(input int n, input logic [31:0] addr);
        int mask = (1 << n) - 1;
        int sh = int'(addr % 4);
        return 4'(mask << sh);
    endfunction

    function automatic logic [31:0] model_load(input int n, input logic uns,
                                               input logic [31:0] addr, input logic [31:0] rd);
        longint v;
        int sh = int'(addr % 4) * 8;
        v = longint'((64'(rd) >> sh) & ((64'd1 << (8 * n)) - 1));
        if (!uns && n < 4 && v >= longint'(64'd1 << (8 * n - 1)))
            v = v - longint'(64'd1 << (8 * n));
        return v[31:0];
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_req(input logic rd, input logic wr, input logic w, input logic h,
                             input logic b, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        lsu_read = rd; lsu_write = wr; lsu_word = w; lsu_hw = h; lsu_byte = b;
        lsu_unsigned = uns; lsu_addr = addr; lsu_wdata = wdata;
    endtask

    task automatic idle_req();
        lsu_read = 0; lsu_write = 0; lsu_word = 0; lsu_hw = 0; lsu_byte = 0;
        lsu_unsigned = 0; lsu_kill = 0; lsu_hold = 0;
    endtask

    // One complete access; slave answers after `delay` extra BUSY cycles.
    task automatic do_access(input logic rd, input logic wr, input logic w, input logic h,
                             input logic b, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int delay,
                             input logic berr, input int hold_cycles);
        int n = nbytes(w, h, b);
        logic [31:0] exp_data;
        @(negedge clk);
        drive_req(rd, wr, w, h, b, uns, addr, wdata);
        #1;
        checks++; if (lsu_stall !== 1'b1) begin failures++; $display("FAIL issue_stall got=%0b exp=1", lsu_stall); end
        @(posedge clk); @(negedge clk);
        checks++; if (wbm_cyc !== 1'b1 || wbm_stb !== 1'b1 || lsu_stall !== 1'b1) begin
            failures++; $display("FAIL busy_cyc cyc=%0b stb=%0b stall=%0b exp=1,1,1", wbm_cyc, wbm_stb, lsu_stall); end
        checks++; if (wbm_adr !== (addr & 32'hFFFF_FFFC)) begin
            failures++; $display("FAIL adr got=%h exp=%h", wbm_adr, addr & 32'hFFFF_FFFC); end
        checks++; if (wbm_sel !== model_sel(n, addr)) begin
            failures++; $display("FAIL sel got=%b exp=%b", wbm_sel, model_sel(n, addr)); end
        checks++; if (wbm_we !== wr) begin failures++; $display("FAIL we got=%0b exp=%0b", wbm_we, wr); end
        checks++; if (wbm_dat !== model_wdat(n, wdata)) begin
            failures++; $display("FAIL wdat got=%h exp=%h", wbm_dat, model_wdat(n, wdata)); end
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (wbm_cyc !== 1'b1 || lsu_stall !== 1'b1) begin
                failures++; $display("FAIL wait_cyc cyc=%0b stall=%0b exp=1,1", wbm_cyc, lsu_stall); end
        end
        wbm_ack = !berr; wbm_err = berr; wbm_dat_in = rdata;
        lsu_hold = (hold_cycles > 0);
        exp_q.push_back((wr || berr) ? 32'h0 : model_load(n, uns, addr, rdata));
        @(posedge clk); @(negedge clk);
        wbm_ack = 0; wbm_err = 0; wbm_dat_in = $urandom;
        exp_data = exp_q.pop_front();
        checks++; if (wbm_cyc !== 1'b0 || lsu_stall !== 1'b0) begin
            failures++; $display("FAIL done_state cyc=%0b stall=%0b exp=0,0", wbm_cyc, lsu_stall); end
        checks++; if (lsu_data !== exp_data || lsu_err !== berr) begin
            failures++; $display("FAIL done_result data=%h err=%0b exp=%h,%0b", lsu_data, lsu_err, exp_data, berr); end
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (lsu_data !== exp_data || lsu_err !== berr || lsu_stall !== 1'b0) begin
                failures++; $display("FAIL hold_result data=%h err=%0b exp=%h,%0b", lsu_data, lsu_err, exp_data, berr); end
        end
        idle_req();
        @(posedge clk); @(negedge clk);
        checks++; if (lsu_data !== 32'h0 || lsu_err !== 1'b0 || lsu_stall !== 1'b0 || wbm_cyc !== 1'b0) begin
            failures++; $display("FAIL back_idle data=%h err=%0b stall=%0b cyc=%0b exp=0", lsu_data, lsu_err, lsu_stall, wbm_cyc); end
    endtask

    // A request that must not start a bus cycle (misaligned or killed).
    task automatic no_issue(input logic rd, input logic wr, input logic w, input logic h,
                            input logic b, input logic [31:0] addr, input logic kill);
        @(negedge clk);
        drive_req(rd, wr, w, h, b, 1'b0, addr, $urandom);
        lsu_kill = kill;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (wbm_cyc !== 1'b0 || lsu_stall !== 1'b0 || lsu_err !== 1'b0) begin
                failures++; $display("FAIL no_issue addr=%h cyc=%0b stall=%0b err=%0b exp=0", addr, wbm_cyc, lsu_stall, lsu_err); end
            @(negedge clk);
        end
        idle_req();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1; idle_req(); lsu_addr = 0; lsu_wdata = 0;
        wbm_ack = 0; wbm_err = 0; wbm_dat_in = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({wbm_cyc, wbm_stb, wbm_we, wbm_sel} !== 7'b0 || wbm_adr !== 0 || wbm_dat !== 0) begin
            failures++; $display("FAIL reset_bus cyc=%0b stb=%0b we=%0b sel=%b adr=%h dat=%h exp=0", wbm_cyc, wbm_stb, wbm_we, wbm_sel, wbm_adr, wbm_dat); end
        checks++; if (lsu_data !== 0 || lsu_err !== 0 || lsu_stall !== 0) begin
            failures++; $display("FAIL reset_lsu data=%h err=%0b stall=%0b exp=0", lsu_data, lsu_err, lsu_stall); end
        rst = 0;
    endtask

    task automatic test_directed();
        do_access(1, 0, 1, 0, 0, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
        do_access(1, 0, 0, 0, 1, 0, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 0);
        do_access(1, 0, 0, 0, 1, 1, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 0);
        do_access(0, 1, 0, 1, 0, 0, 32'h202, 32'h0000_ABCD, 32'h1111_1111, 0, 0, 0);
        do_access(1, 0, 0, 1, 0, 0, 32'h302, 32'h0, 32'h8001_7FFF, 1, 0, 2);
        do_access(1, 0, 1, 0, 0, 0, 32'h400, 32'h0, 32'h5555_5555, 2, 1, 1);
        do_access(1, 0, 1, 0, 0, 0, 32'h404, 32'h0, 32'hCAFE_F00D, 3, 0, 0);
    endtask

    task automatic test_misaligned();
        no_issue(1, 0, 1, 0, 0, 32'h101, 0);
        no_issue(0, 1, 0, 1, 0, 32'h203, 0);
        no_issue(1, 0, 0, 0, 0, 32'h302, 0);
        no_issue(1, 0, 1, 0, 0, 32'h100, 1);
    endtask

    task automatic test_timeout();
        int cyc_cycles = 0;
        @(negedge clk);
        drive_req(1, 0, 1, 0, 0, 0, 32'h500, 32'h0);
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wbm_cyc !== 1'b1) break;
            cyc_cycles++;
            @(posedge clk);
        end
        checks++; if (cyc_cycles != 4) begin failures++; $display("FAIL timeout_len got=%0d exp=4", cyc_cycles); end
        checks++; if (lsu_err !== 1'b1 || lsu_data !== 32'h0 || lsu_stall !== 1'b0) begin
            failures++; $display("FAIL timeout_done err=%0b data=%h stall=%0b exp=1,0,0", lsu_err, lsu_data, lsu_stall); end
        idle_req();
        @(posedge clk);
    endtask

    task automatic test_kill_busy();
        @(negedge clk);
        drive_req(1, 0, 1, 0, 0, 0, 32'h600, 32'h0);
        @(posedge clk); @(negedge clk);
        lsu_kill = 1;
        #1;
        checks++; if (lsu_stall !== 1'b1 || wbm_cyc !== 1'b1) begin
            failures++; $display("FAIL kill_stall stall=%0b cyc=%0b exp=1,1", lsu_stall, wbm_cyc); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); @(negedge clk);
            lsu_kill = 0;
            checks++; if (lsu_stall !== 1'b1) begin failures++; $display("FAIL kill_hold_stall got=%0b exp=1", lsu_stall); end
        end
        @(posedge clk); @(negedge clk);
        wbm_ack = 1; wbm_dat_in = 32'h1234_5678; idle_req();
        @(posedge clk); @(negedge clk);
        wbm_ack = 0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (wbm_cyc !== 0 || lsu_stall !== 0 || lsu_data !== 0 || lsu_err !== 0) begin
                failures++; $display("FAIL kill_no_done cyc=%0b stall=%0b data=%h err=%0b exp=0", wbm_cyc, lsu_stall, lsu_data, lsu_err); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_req(0, 1, 1, 0, 0, 0, 32'h700, 32'h0BAD_F00D);
        @(posedge clk); @(negedge clk);
        checks++; if (wbm_cyc !== 1'b1) begin failures++; $display("FAIL rstmid_pre cyc=%0b exp=1", wbm_cyc); end
        rst = 1; idle_req();
        @(posedge clk); @(negedge clk);
        rst = 0;
        checks++; if (wbm_cyc !== 0 || wbm_stb !== 0 || wbm_we !== 0 || lsu_stall !== 0) begin
            failures++; $display("FAIL rstmid_drop cyc=%0b stb=%0b we=%0b stall=%0b exp=0", wbm_cyc, wbm_stb, wbm_we, lsu_stall); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            logic rd, wr, w, h, b, uns;
            logic [31:0] addr;
            int n;
            rd = 1'($urandom); wr = 1'($urandom);
            if (!rd && !wr) rd = 1;
            w = 1'($urandom); h = 1'($urandom); b = 1'($urandom); uns = 1'($urandom);
            n = nbytes(w, h, b);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(n - 1);
            if (is_misaligned(n, addr))
                no_issue(rd, wr, w, h, b, addr, 0);
            else
                do_access(rd, wr, w, h, b, uns, addr, $urandom, $urandom,
                          $urandom_range(0, 3), ($urandom_range(0, 9) == 0), $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_misaligned();
        test_timeout();
        test_kill_busy();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
